// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
//   port_e            : identifies a requester (CPU or UART loader port)
//   CONFLICT_CNT_W    : width of the contention statistics counter
//   CONFLICT_CNT_MAX  : saturation value of that counter
package dmem_arb_pkg;

    typedef enum logic {
        PORT_CPU  = 1'b0,
        PORT_UART = 1'b1
    } port_e;

    localparam int CONFLICT_CNT_W = 16;
    localparam logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT_MAX = '1;

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter with a registered last-grant pointer.
//   clk, rst             : clock, synchronous active-high reset
//   req_cpu, req_uart    : eligible requests (already qualified by the caller)
//   gnt_cpu, gnt_uart    : combinational one-hot (or zero) grant
// When both request, the port that did not win most recently is granted.
// Reset leaves the pointer at CPU so that UART wins the first contention.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_cpu,
    input  logic req_uart,
    output logic gnt_cpu,
    output logic gnt_uart
);

    port_e last_reg;

    always_comb begin
        gnt_cpu  = req_cpu  && (!req_uart || (last_reg == PORT_UART));
        gnt_uart = req_uart && (!req_cpu  || (last_reg == PORT_CPU));
    end

    // Pointer moves only when someone is actually granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= PORT_CPU;
        end else if (gnt_cpu) begin
            last_reg <= PORT_CPU;
        end else if (gnt_uart) begin
            last_reg <= PORT_UART;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates a single-port synchronous data memory between the CPU (read/write)
// and the UART loader (read only).
//   clk, rst                      : clock, synchronous active-high reset
//   uart_excl                     : UART-only mode, CPU requests are ignored
//   cpu_req/we/addr/be/wdata      : CPU request, held until cpu_gnt
//   cpu_gnt/rvalid/rdata          : CPU grant and read return (1-cycle latency)
//   uart_req/addr                 : UART read request, held until uart_gnt
//   uart_gnt/rvalid/rdata         : UART grant and read return
//   mem_en/we/addr/be/wdata/rdata : memory port (rdata valid one cycle after a read)
//   conflict_cnt                  : saturating count of cycles with both eligible
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      uart_excl,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr,
    input  logic [BE_WIDTH-1:0]       cpu_be,
    input  logic [DATA_WIDTH-1:0]     cpu_wdata,
    output logic                      cpu_gnt,
    output logic                      cpu_rvalid,
    output logic [DATA_WIDTH-1:0]     cpu_rdata,
    input  logic                      uart_req,
    input  logic [ADDR_WIDTH-1:0]     uart_addr,
    output logic                      uart_gnt,
    output logic                      uart_rvalid,
    output logic [DATA_WIDTH-1:0]     uart_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [BE_WIDTH-1:0]       mem_be,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

    logic cpu_elig;
    logic uart_elig;
    logic cpu_rvalid_reg;
    logic uart_rvalid_reg;
    logic [DATA_WIDTH-1:0] cpu_rdata_reg;
    logic [DATA_WIDTH-1:0] uart_rdata_reg;
    logic [CONFLICT_CNT_W-1:0] conflict_cnt_reg;

    // Reset masks eligibility so no grant or memory access leaks out during rst.
    assign cpu_elig  = cpu_req && !uart_excl && !rst;
    assign uart_elig = uart_req && !rst;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .req_cpu  (cpu_elig),
        .req_uart (uart_elig),
        .gnt_cpu  (cpu_gnt),
        .gnt_uart (uart_gnt)
    );

    // Memory port mux; idle cycles drive zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_be    = cpu_be;
            mem_wdata = cpu_wdata;
        end else if (uart_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = uart_addr;
            mem_be    = '1;
        end
    end

    // Read ownership is tracked per port so a later uart_excl change cannot
    // steal a CPU read that is already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid_reg  <= 1'b0;
            uart_rvalid_reg <= 1'b0;
        end else begin
            cpu_rvalid_reg  <= cpu_gnt && !cpu_we;
            uart_rvalid_reg <= uart_gnt;
        end
    end

    // Memory data is passed through in the return cycle and captured so the
    // port keeps showing its last read afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_reg  <= '0;
            uart_rdata_reg <= '0;
        end else begin
            if (cpu_rvalid_reg) begin
                cpu_rdata_reg <= mem_rdata;
            end
            if (uart_rvalid_reg) begin
                uart_rdata_reg <= mem_rdata;
            end
        end
    end

    assign cpu_rvalid  = cpu_rvalid_reg;
    assign uart_rvalid = uart_rvalid_reg;
    assign cpu_rdata   = cpu_rvalid_reg  ? mem_rdata : cpu_rdata_reg;
    assign uart_rdata  = uart_rvalid_reg ? mem_rdata : uart_rdata_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_reg <= '0;
        end else if (cpu_elig && uart_elig && (conflict_cnt_reg != CONFLICT_CNT_MAX)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
        end
    end

    assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed plus randomized bench for dmem_port_arbiter with a behavioural
// reference model (round-robin rule, shadow memory, expected read returns).
module tb_dmem_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          uart_excl;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [BW-1:0] cpu_be;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          uart_req;
    logic [AW-1:0] uart_addr;
    logic          uart_gnt;
    logic          uart_rvalid;
    logic [DW-1:0] uart_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   conflict_cnt;

    int checks = 0;
    int failures = 0;

    dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_excl    (uart_excl),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_be       (cpu_be),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .uart_req     (uart_req),
        .uart_addr    (uart_addr),
        .uart_gnt     (uart_gnt),
        .uart_rvalid  (uart_rvalid),
        .uart_rdata   (uart_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return {8'(i * 3 + 17), 8'(i * 5 + 34), 8'(i * 7 + 51), 8'(i * 11 + 68)};
    endfunction

    // Memory environment: synchronous RAM, reloaded with known content during reset.
    logic [DW-1:0] env_mem [NW];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) env_mem[i] <= init_word(i);
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) env_mem[mem_addr[AW-1:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= env_mem[mem_addr[AW-1:2]];
            end
        end
    end

    // Reference model state.
    logic [DW-1:0] shadow [NW];
    bit            m_prio_uart;
    int            m_cnt;
    logic          m_cpu_rv, m_uart_rv;
    logic [DW-1:0] m_cpu_rd, m_uart_rd;

    // Values observed in the most recent step, for directed checks.
    logic          s_cg, s_ug, s_men, s_cpu_rv, s_uart_rv;
    logic [DW-1:0] s_uart_rd;
    logic [15:0]   s_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check all outputs mid-cycle against the model, then advance the model.
    task automatic step();
        logic ec, eu, gc, gu;
        logic [AW-1:0] ea;
        logic [BW-1:0] eb;
        logic [DW-1:0] ew;
        @(negedge clk);
        ec = cpu_req && !uart_excl && !rst;
        eu = uart_req && !rst;
        if (ec && eu) begin
            gu = m_prio_uart;
            gc = !m_prio_uart;
        end else begin
            gc = ec;
            gu = eu;
        end
        ea = gc ? cpu_addr  : (gu ? uart_addr : '0);
        eb = gc ? cpu_be    : (gu ? 4'hF : 4'h0);
        ew = gc ? cpu_wdata : '0;
        chk("cpu_gnt",     32'(cpu_gnt),     32'(gc));
        chk("uart_gnt",    32'(uart_gnt),    32'(gu));
        chk("mem_en",      32'(mem_en),      32'(gc || gu));
        chk("mem_we",      32'(mem_we),      32'(gc && cpu_we));
        chk("mem_addr",    32'(mem_addr),    32'(ea));
        chk("mem_be",      32'(mem_be),      32'(eb));
        chk("mem_wdata",   mem_wdata,        ew);
        chk("cpu_rvalid",  32'(cpu_rvalid),  32'(m_cpu_rv));
        chk("uart_rvalid", 32'(uart_rvalid), 32'(m_uart_rv));
        chk("cpu_rdata",   cpu_rdata,        m_cpu_rd);
        chk("uart_rdata",  uart_rdata,       m_uart_rd);
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
        s_cg = cpu_gnt; s_ug = uart_gnt; s_men = mem_en;
        s_cpu_rv = cpu_rvalid; s_uart_rv = uart_rvalid;
        s_uart_rd = uart_rdata; s_cnt = conflict_cnt;
        @(posedge clk);
        if (rst) begin
            m_prio_uart = 1'b1;
            m_cnt = 0;
            m_cpu_rv = 1'b0; m_uart_rv = 1'b0;
            m_cpu_rd = '0;   m_uart_rd = '0;
            for (int i = 0; i < NW; i++) shadow[i] = init_word(i);
        end else begin
            if (ec && eu && m_cnt < 65535) m_cnt++;
            if (gc || gu) m_prio_uart = gc;
            m_cpu_rv  = gc && !cpu_we;
            m_uart_rv = gu;
            if (gc && !cpu_we) m_cpu_rd  = shadow[cpu_addr[AW-1:2]];
            if (gu)            m_uart_rd = shadow[uart_addr[AW-1:2]];
            if (gc && cpu_we)
                for (int b = 0; b < BW; b++)
                    if (cpu_be[b]) shadow[cpu_addr[AW-1:2]][b*8 +: 8] = cpu_wdata[b*8 +: 8];
        end
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
        uart_req = 0; uart_addr = '0;
    endtask

    initial begin : main
        logic [5:0]  seq;
        logic [31:0] w2;
        m_prio_uart = 1'b1; m_cnt = 0;
        m_cpu_rv = 0; m_uart_rv = 0; m_cpu_rd = '0; m_uart_rd = '0;
        for (int i = 0; i < NW; i++) shadow[i] = init_word(i);

        // Reset with both ports requesting: no grants allowed.
        rst = 1; uart_excl = 0; idle_inputs();
        cpu_req = 1; uart_req = 1; cpu_addr = 6'h10; uart_addr = 6'h14;
        repeat (3) step();
        rst = 0; idle_inputs();
        step();
        chk("rst_cpu_rvalid", 32'(s_cpu_rv), 32'd0);
        chk("rst_uart_rdata", s_uart_rd, 32'd0);
        chk("rst_conflict",   32'(s_cnt), 32'd0);
        $display("reset released");

        // UART-exclusive read of 0x04.
        uart_excl = 1; uart_req = 1; uart_addr = 6'h04;
        step();
        chk("excl_uart_gnt", 32'(s_ug), 32'd1);
        uart_req = 0;
        step();
        chk("excl_uart_rvalid", 32'(s_uart_rv), 32'd1);
        chk("excl_uart_rdata",  s_uart_rd, init_word(1));
        $display("uart read addr=04 data=%h", s_uart_rd);

        // CPU held off for 10 cycles while UART has exclusive access.
        cpu_req = 1; cpu_addr = 6'h0C;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("excl_cpu_gnt", 32'(s_cg), 32'd0);
            chk("excl_mem_en",  32'(s_men), 32'd0);
        end
        $display("cpu blocked 10 cycles under uart_excl");

        // Fresh reset, then continuous contention: UART,CPU alternate.
        idle_inputs(); uart_excl = 0; rst = 1; step(); rst = 0;
        cpu_req = 1; cpu_addr = 6'h10; uart_req = 1; uart_addr = 6'h14;
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            seq = {seq[4:0], s_ug};
            $display("contention cycle %0d cpu_gnt=%0b uart_gnt=%0b", i, s_cg, s_ug);
        end
        idle_inputs();
        step();
        chk("rr_sequence", 32'(seq), 32'(6'b101010));
        chk("rr_conflict", 32'(s_cnt), 32'd6);

        // Partial write then UART read-back.
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'h08; cpu_be = 4'b0011; cpu_wdata = 32'hDEADBEEF;
        step();
        idle_inputs(); uart_req = 1; uart_addr = 6'h08;
        step();
        idle_inputs();
        step();
        w2 = init_word(2);
        chk("be_low_half",  32'(s_uart_rd[15:0]),  32'h0000BEEF);
        chk("be_high_half", 32'(s_uart_rd[31:16]), 32'(w2[31:16]));
        $display("uart readback addr=08 data=%h", s_uart_rd);

        // CPU read in flight when uart_excl rises.
        cpu_req = 1; cpu_addr = 6'h0C;
        step();
        cpu_req = 0; uart_excl = 1;
        step();
        chk("excl_rise_rvalid", 32'(s_cpu_rv), 32'd1);
        uart_excl = 0;
        // CPU read in flight when reset hits.
        cpu_req = 1; cpu_addr = 6'h18;
        step();
        cpu_req = 0; rst = 1;
        step();
        rst = 0;
        step();
        chk("rst_kill_rvalid", 32'(s_cpu_rv), 32'd0);
        $display("in-flight read cases done");

        // Randomized traffic with request-hold protocol.
        for (int i = 0; i < 400; i++) begin
            if (!cpu_req || s_cg) begin
                cpu_req = ($urandom_range(0, 3) != 0);
                cpu_we = $urandom_range(0, 1) == 1;
                cpu_addr = 6'($urandom_range(0, 63));
                cpu_be = 4'($urandom_range(0, 15));
                cpu_wdata = $urandom;
            end
            if (!uart_req || s_ug) begin
                uart_req = ($urandom_range(0, 2) != 0);
                uart_addr = 6'($urandom_range(0, 63));
            end
            uart_excl = ($urandom_range(0, 7) == 0);
            step();
        end
        $display("random phase done conflict_cnt=%0d", s_cnt);

        // Saturation of the conflict counter.
        uart_excl = 0; cpu_req = 1; cpu_we = 0; uart_req = 1;
        for (int i = 0; i < 65540; i++) step();
        idle_inputs();
        step();
        chk("conflict_saturate", 32'(s_cnt), 32'h0000FFFF);
        $display("saturation conflict_cnt=%h", s_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, byte-address width of data memory.
REQ-002 Parameter DATA_WIDTH, default 32, memory word width; multiple of 8; BE_WIDTH = DATA_WIDTH/8.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 uart_excl  in  1  high: only UART port eligible for grant (CPU held in reset).
REQ-006 cpu_req  in  1  CPU access request; held stable until cpu_gnt.
REQ-007 cpu_we  in  1  1 = write, 0 = read.
REQ-008 cpu_addr  in  ADDR_WIDTH  CPU byte address.
REQ-009 cpu_be  in  BE_WIDTH  CPU write byte enables.
REQ-010 cpu_wdata  in  DATA_WIDTH  CPU write data.
REQ-011 cpu_gnt  out  1  CPU request accepted this cycle.
REQ-012 cpu_rvalid  out  1  CPU read data valid.
REQ-013 cpu_rdata  out  DATA_WIDTH  CPU read data.
REQ-014 uart_req  in  1  UART read request; held stable until uart_gnt.
REQ-015 uart_addr  in  ADDR_WIDTH  UART byte address.
REQ-016 uart_gnt  out  1  UART request accepted this cycle.
REQ-017 uart_rvalid  out  1  UART read data valid.
REQ-018 uart_rdata  out  DATA_WIDTH  UART read data.
REQ-019 mem_en, mem_we  out  1 each  memory enable / write enable.
REQ-020 mem_addr  out  ADDR_WIDTH; mem_be  out  BE_WIDTH; mem_wdata  out  DATA_WIDTH.
REQ-021 mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_en && !mem_we.
REQ-022 conflict_cnt  out  16  count of cycles with both requests eligible.

Function
REQ-023 Grant combinational from current requests and registered priority pointer; at most one of cpu_gnt/uart_gnt high per cycle.
REQ-024 CPU eligible only when cpu_req && !uart_excl; UART eligible when uart_req.
REQ-025 Single eligible requester is granted same cycle.
REQ-026 Both eligible: grant goes to port not granted most recently (round-robin); after reset, UART has priority.
REQ-027 Priority pointer updates only on a grant, to the granted port.
REQ-028 mem_en = cpu_gnt | uart_gnt; mem_addr/mem_be/mem_wdata/mem_we driven from granted port; UART grant forces mem_we=0, mem_be=all-ones.
REQ-029 No grant: mem_en=0, mem_we=0; other mem outputs don't-care but SHALL be 0.
REQ-030 Read grant at cycle N: owner's rvalid high exactly at N+1, rdata = mem_rdata; 1-cycle latency, one read in flight per cycle, back-to-back reads sustained.
REQ-031 Write grant produces no rvalid.
REQ-032 Non-owner rdata held at last value; rvalid low.
REQ-033 uart_excl rising while CPU read granted at N: cpu_rvalid still delivered at N+1.
REQ-034 conflict_cnt increments when both eligible, saturates at 16'hFFFF.

Reset
REQ-035 During rst: cpu_gnt, uart_gnt, mem_en, mem_we = 0 regardless of requests.
REQ-036 After rst: cpu_rvalid=0, uart_rvalid=0, cpu_rdata=0, uart_rdata=0, conflict_cnt=0, priority=UART.
REQ-037 rst asserted cycle after a read grant: rvalid suppressed (0 the following cycle).

Structure
REQ-038 Package dmem_arb_pkg: enum port_e {PORT_CPU, PORT_UART}, conflict counter width constant.
REQ-039 Sub-module rr_arb2: 2-requester round-robin arbiter with registered last-grant pointer.

Verification
REQ-040 Reset, uart_excl=1, uart_req addr 0x04 -> uart_gnt same cycle, mem_addr=0x04, uart_rvalid next cycle with preloaded data.
REQ-041 uart_excl=1, cpu_req held 10 cycles -> cpu_gnt never asserts, mem_en=0.
REQ-042 uart_excl=0, both requesting continuously 6 cycles -> grants UART,CPU,UART,CPU,UART,CPU; conflict_cnt=6.
REQ-043 CPU write 0xDEADBEEF be=4'b0011 addr 0x08, then UART read 0x08 -> uart_rdata lower 16 bits 0xBEEF, upper bytes unchanged.
REQ-044 CPU read grant cycle N, uart_excl rises N+1 -> cpu_rvalid=1 at N+1; rst at N+1 instead -> cpu_rvalid=0 at N+2.
REQ-045 Force 65540 conflict cycles -> conflict_cnt=16'hFFFF, no wrap.
